// File: rtl/padstop_pkg.sv
// -----------------------------------------------------------------------------
// padstop_pkg
// Shared constants for the pad-level matrix-multiplication peripheral:
//   - operand/result widths
//   - FSM state codes (IDLE, LOAD, COMPUTE, OUTPUT)
//   - P_sel field codes for the narrow readout port
//   - coefficient ROM function A[i][j] = 8*i + j + 1
// -----------------------------------------------------------------------------
package padstop_pkg;

    localparam int DATA_W = 8;                  // X element width
    localparam int COEF_W = 7;                  // A element width
    localparam int RES_W  = DATA_W + COEF_W + 3; // 18, read out as two 9-bit halves

    // FSM state codes
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_LOAD    = 2'd1;
    localparam state_t ST_COMPUTE = 2'd2;
    localparam state_t ST_OUTPUT  = 2'd3;

    // P_sel field codes
    localparam logic [1:0] PSEL_LO   = 2'b00;   // result bits [8:0]
    localparam logic [1:0] PSEL_HI   = 2'b01;   // result bits [17:9]
    localparam logic [1:0] PSEL_STAT = 2'b10;   // {0, valid, 000, out_idx}
    localparam logic [1:0] PSEL_PAR  = 2'b11;   // parity or zero

    // Coefficient ROM: {i, j} is 8*i + j, so A ranges over 1..32.
    function automatic logic [COEF_W-1:0] coef(input logic [1:0] i, input logic [2:0] j);
        return {2'b00, i, j} + 7'd1;
    endfunction

endpackage

// File: rtl/padstop_mac2.sv
// -----------------------------------------------------------------------------
// padstop_mac2
// Dual multiply-accumulate: each enabled cycle adds a1*x1 + a2*x2 to an 18-bit
// accumulator. 'clear' starts a new sum from zero (this cycle's products are
// still added), so a result takes exactly four enabled cycles with no gap.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           discard the running sum before adding this cycle's products
//   enable          commit the new sum to the accumulator
//   a1, a2          coefficients (COEF_W bits)
//   x1, x2          data elements (DATA_W bits)
//   acc             running sum including this cycle's products (combinational),
//                   so the caller can capture a finished result on its last step
// -----------------------------------------------------------------------------
module padstop_mac2
    import padstop_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              enable,
    input  logic [COEF_W-1:0] a1,
    input  logic [COEF_W-1:0] a2,
    input  logic [DATA_W-1:0] x1,
    input  logic [DATA_W-1:0] x2,
    output logic [RES_W-1:0]  acc
);

    logic [RES_W-1:0] acc_q;
    logic [RES_W-1:0] prod_sum;

    // Max 32*255*8 = 65280 < 2^18: widening to RES_W before the multiply is enough.
    assign prod_sum = RES_W'(a1) * RES_W'(x1) + RES_W'(a2) * RES_W'(x2);
    assign acc      = (clear ? '0 : acc_q) + prod_sum;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (enable) begin
            acc_q <= acc;
        end
    end

endmodule

// File: rtl/padstop_matmul.sv
// -----------------------------------------------------------------------------
// padstop_matmul
// Pad-level top of the matrix-multiplication peripheral. Loads an 8x4 matrix X
// serially (one byte per clock, column-major), computes P = A*X with the fixed
// 4x8 coefficient ROM using two parallel MACs (4 cycles per result, 64 total),
// then presents the 16 18-bit results through a 9-bit port selected by P_sel.
// A P_sel wrap (11 -> 00) advances the readout index; the wrap after index 15
// ends the pass.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   start           begin a pass (sampled only in IDLE)
//   X_load[7:0]     serial X byte, captured while input_load_en=1
//   P_sel[1:0]      field select / readout pacing
//   P_out[8:0]      selected field of result[out_idx] or status
//   input_load_en   high while X bytes are accepted
//   Xload_done      one-cycle pulse in the first COMPUTE cycle
//
// Configuration:
//   PADSTOP_PARITY_EN  when defined, P_sel=11 returns the even parity of the
//                      selected result; otherwise it returns 0.
// -----------------------------------------------------------------------------
module padstop_matmul
    import padstop_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] X_load,
    input  logic [1:0] P_sel,
    output logic [8:0] P_out,
    output logic       input_load_en,
    output logic       Xload_done
);

    state_t            state;
    logic [4:0]        load_cnt;        // byte index n during LOAD
    logic [5:0]        comp_cnt;        // {result idx, step m} during COMPUTE
    logic [DATA_W-1:0] x_mem [8][4];    // x_mem[row][col]
    logic [RES_W-1:0]  res_mem [16];
    logic              valid;
    logic [3:0]        out_idx;
    logic [1:0]        prev_psel;
    logic              xload_done_q;

    // COMPUTE decoding: idx = 4*i + k, step m selects coefficient columns 2m, 2m+1
    logic [1:0]        row_i;
    logic [1:0]        col_k;
    logic [1:0]        step_m;
    logic [COEF_W-1:0] mac_a1, mac_a2;
    logic [DATA_W-1:0] mac_x1, mac_x2;
    logic [RES_W-1:0]  mac_acc;
    logic              mac_clear, mac_en;
    logic [RES_W-1:0]  sel_res;
    logic              psel_wrap;

    assign row_i     = comp_cnt[5:4];
    assign col_k     = comp_cnt[3:2];
    assign step_m    = comp_cnt[1:0];
    assign mac_clear = (step_m == 2'd0);
    assign mac_en    = (state == ST_COMPUTE);

    // NOTE: every signal assigned in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        mac_a1 = coef(row_i, {step_m, 1'b0});
        mac_a2 = coef(row_i, {step_m, 1'b1});
        mac_x1 = x_mem[{step_m, 1'b0}][col_k];
        mac_x2 = x_mem[{step_m, 1'b1}][col_k];
    end

    padstop_mac2 u_mac2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (mac_clear),
        .enable (mac_en),
        .a1     (mac_a1),
        .a2     (mac_a2),
        .x1     (mac_x1),
        .x2     (mac_x2),
        .acc    (mac_acc)
    );

    assign psel_wrap     = (prev_psel == PSEL_PAR) && (P_sel == PSEL_LO);
    assign input_load_en = (state == ST_LOAD);
    assign Xload_done    = xload_done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            load_cnt     <= '0;
            comp_cnt     <= '0;
            valid        <= 1'b0;
            out_idx      <= '0;
            prev_psel    <= '0;
            xload_done_q <= 1'b0;
            // NOTE: the register files are reset too, because a reset must
            // discard all data and P_out has to read 0 afterwards; this is
            // cheap here but is not the default choice for large memories.
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 4; c++) begin
                    x_mem[r][c] <= '0;
                end
            end
            for (int n = 0; n < 16; n++) begin
                res_mem[n] <= '0;
            end
        end else begin
            prev_psel    <= P_sel;
            xload_done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_LOAD;
                        load_cnt <= '0;
                    end
                end
                ST_LOAD: begin
                    // Byte n goes to row n%8, column n/8.
                    x_mem[load_cnt[2:0]][load_cnt[4:3]] <= X_load;
                    load_cnt <= load_cnt + 5'd1;
                    if (load_cnt == 5'd31) begin
                        state        <= ST_COMPUTE;
                        comp_cnt     <= '0;
                        xload_done_q <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    comp_cnt <= comp_cnt + 6'd1;
                    if (step_m == 2'd3) begin
                        res_mem[comp_cnt[5:2]] <= mac_acc;
                    end
                    if (comp_cnt == 6'd63) begin
                        state   <= ST_OUTPUT;
                        valid   <= 1'b1;
                        out_idx <= '0;
                    end
                end
                ST_OUTPUT: begin
                    if (psel_wrap) begin
                        if (out_idx == 4'd15) begin
                            // Index stays at 15 so the last result remains readable.
                            valid <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            out_idx <= out_idx + 4'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sel_res = res_mem[out_idx];

    always_comb begin
        P_out = 9'd0;
        case (P_sel)
            PSEL_LO:   P_out = sel_res[8:0];
            PSEL_HI:   P_out = sel_res[17:9];
            PSEL_STAT: P_out = {1'b0, valid, 3'b000, out_idx};
`ifdef PADSTOP_PARITY_EN
            PSEL_PAR:  P_out = {8'b0, ^sel_res};
`else
            PSEL_PAR:  P_out = 9'd0;
`endif
            default:   P_out = 9'd0;
        endcase
    end

endmodule

// File: tb/tb_padstop_matmul.sv
// -----------------------------------------------------------------------------
// tb_padstop_matmul
// Self-checking bench for padstop_matmul. Expected results come from a plain
// arithmetic model of P = A*X with A[i][j] = 8*i + j + 1 and X[j][k] = byte
// 8*k + j, or from closed-form constants for the directed patterns.
// -----------------------------------------------------------------------------
module tb_padstop_matmul;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] X_load;
    logic [1:0] P_sel;
    logic [8:0] P_out;
    logic       input_load_en;
    logic       Xload_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  bytes_q [32];
    logic [17:0] exp_res [16];

    padstop_matmul dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .X_load        (X_load),
        .P_sel         (P_sel),
        .P_out         (P_out),
        .input_load_en (input_load_en),
        .Xload_done    (Xload_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit (got timeout, required completion)");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] exp_par(input logic [17:0] r);
`ifdef PADSTOP_PARITY_EN
        return {8'b0, ^r};
`else
        return 9'd0 & {9{^r}};
`endif
    endfunction

    // P[i][k] = sum_j (8i+j+1) * X[j][k], X[j][k] = bytes_q[8k+j]
    task automatic build_model();
        for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < 4; k++) begin
                int s = 0;
                for (int j = 0; j < 8; j++) begin
                    s += (8 * i + j + 1) * int'(bytes_q[8 * k + j]);
                end
                exp_res[4 * i + k] = 18'(s);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts from IDLE just after a clock edge; returns at the cycle valid rises.
    task automatic do_load();
        int len;
        int c;
        start = 1'b1;
        #1;
        n_checks++;
        if (input_load_en !== 1'b0) begin
            n_fail++;
            $display("FAIL load_idle_en: got %b, required 0", input_load_en);
        end
        tick();
        start = 1'b0;
        len = 0;
        for (int n = 0; n < 32; n++) begin
            X_load = bytes_q[n];
            if (input_load_en === 1'b1) len++;
            tick();
        end
        X_load = 8'h00;
        n_checks++;
        if (len != 32 || input_load_en !== 1'b0) begin
            n_fail++;
            $display("FAIL load_window: got %0d cycles (en now %b), required 32 (en 0)", len, input_load_en);
        end
        n_checks++;
        if (Xload_done !== 1'b1) begin
            n_fail++;
            $display("FAIL xload_done_pulse: got %b, required 1", Xload_done);
        end
        P_sel = 2'b10;
        c = 0;
        while (c < 200) begin
            tick();
            c++;
            if (c == 1) begin
                n_checks++;
                if (Xload_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL xload_done_width: got %b, required 0", Xload_done);
                end
            end
            if (P_out[7] === 1'b1) break;
        end
        n_checks++;
        if (c != 64) begin
            n_fail++;
            $display("FAIL valid_latency: got %0d cycles, required 64", c);
        end
    endtask

    // Cycles P_sel 00,01,10,11 (two cycles each) through all 16 results.
    task automatic read_all(input bit hold_start);
        for (int idx = 0; idx < 16; idx++) begin
            P_sel = 2'b00;
            tick();
            n_checks++;
            if (P_out !== exp_res[idx][8:0]) begin
                n_fail++;
                $display("FAIL read_lo[%0d]: got %0d, required %0d", idx, P_out, exp_res[idx][8:0]);
            end
            tick();
            P_sel = 2'b01;
            tick();
            n_checks++;
            if (P_out !== exp_res[idx][17:9]) begin
                n_fail++;
                $display("FAIL read_hi[%0d]: got %0d, required %0d", idx, P_out, exp_res[idx][17:9]);
            end
            tick();
            P_sel = 2'b10;
            tick();
            n_checks++;
            if (P_out !== {1'b0, 1'b1, 3'b000, 4'(idx)}) begin
                n_fail++;
                $display("FAIL read_stat[%0d]: got %h, required %h", idx, P_out, {1'b0, 1'b1, 3'b000, 4'(idx)});
            end
            tick();
            if (idx == 15 && hold_start) start = 1'b1;
            P_sel = 2'b11;
            tick();
            n_checks++;
            if (P_out !== exp_par(exp_res[idx])) begin
                n_fail++;
                $display("FAIL read_par[%0d]: got %0d, required %0d", idx, P_out, exp_par(exp_res[idx]));
            end
            tick();
        end
        P_sel = 2'b00;
        tick();
        P_sel = 2'b10;
        #1;
        n_checks++;
        if (P_out[7] !== 1'b0 || input_load_en !== 1'b0) begin
            n_fail++;
            $display("FAIL pass_end: got valid %b en %b, required valid 0 en 0", P_out[7], input_load_en);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        X_load = 8'h00;
        P_sel = 2'b00;
        #23;
        for (int s = 0; s < 4; s++) begin
            P_sel = 2'(s);
            #1;
            n_checks++;
            if (P_out !== 9'd0) begin
                n_fail++;
                $display("FAIL reset_pout[%0d]: got %0d, required 0", s, P_out);
            end
        end
        n_checks++;
        if (input_load_en !== 1'b0 || Xload_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got en %b done %b, required 0 0", input_load_en, Xload_done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_all_ones();
        for (int n = 0; n < 32; n++) bytes_q[n] = 8'h01;
        // Row sums of A: 36 + 64*i
        for (int idx = 0; idx < 16; idx++) exp_res[idx] = 18'(36 + 64 * (idx / 4));
        do_load();
        read_all(1'b0);
    endtask

    task automatic test_max();
        for (int n = 0; n < 32; n++) bytes_q[n] = 8'hFF;
        build_model();
        do_load();
        read_all(1'b0);
    endtask

    task automatic test_back_to_back();
        for (int p = 0; p < 3; p++) begin
            for (int n = 0; n < 32; n++) bytes_q[n] = 8'($urandom);
            build_model();
            do_load();
            read_all(p < 2);
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        int en_seen;
        for (int n = 0; n < 32; n++) bytes_q[n] = 8'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int n = 0; n < 10; n++) begin
            X_load = bytes_q[n];
            tick();
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (input_load_en !== 1'b0 || Xload_done !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_ctrl: got en %b done %b, required 0 0", input_load_en, Xload_done);
        end
        for (int s = 0; s < 4; s++) begin
            P_sel = 2'(s);
            #1;
            n_checks++;
            if (P_out !== 9'd0) begin
                n_fail++;
                $display("FAIL midreset_pout[%0d]: got %0d, required 0", s, P_out);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        P_sel = 2'b10;
        en_seen = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (input_load_en === 1'b1) en_seen++;
        end
        n_checks++;
        if (en_seen != 0 || P_out !== 9'd0) begin
            n_fail++;
            $display("FAIL midreset_idle: got %0d load cycles, status %h, required 0 and 0", en_seen, P_out);
        end
        build_model();
        do_load();
        read_all(1'b0);
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_max();
        test_back_to_back();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
